spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter MOSI_LEN, default 12, bits per frame received on mosi.
REQ-002 Parameter MISO_LEN, default 8, bits per frame sent on miso; MISO_LEN <= MOSI_LEN.
REQ-003 Parameter SYNC_STAGES, default 2, synchronizer depth on sck, ss and mosi.
REQ-004 clk  input  1  system clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  asynchronous reset, active low.
REQ-006 sck  input  1  SPI clock from the master; idles high.
REQ-007 ss  input  1  slave select from the master, active low.
REQ-008 mosi  input  1  serial data from the master.
REQ-009 miso  output  1  serial data to the master.
REQ-010 tx_data  input  MISO_LEN  word to send; captured at frame start.
REQ-011 rx_data  output  MOSI_LEN  last complete received word.
REQ-012 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-013 busy  output  1  high while a frame is in progress.
REQ-014 frame_err  output  1  one-cycle pulse when ss deasserts mid-frame.

Function
REQ-015 sck, ss and mosi shall each pass through SYNC_STAGES flops before any use; the sampled mosi shall be taken from the same stage as sck.
REQ-016 Protocol is CPOL=1, MSB first. The slave samples mosi on each detected sck rising edge.
REQ-017 The slave drives miso: first bit at frame start, then the next bit one clk after each detected sck rising edge.
REQ-018 Correct operation requires sck high and low phases of at least 2 clk cycles each; faster sck is out of scope.
REQ-019 FSM states: IDLE, ACTIVE, DONE.
REQ-020 IDLE -> ACTIVE on detected synchronized ss falling edge.
  - tx_data is latched into the shift register.
  - miso = tx_data[MISO_LEN-1].
  - Bit counter cleared; busy = 1.
REQ-021 ACTIVE, per sck rising edge: shift in the mosi bit, increment the counter, and advance miso.
  - Once MISO_LEN bits have been sent, miso = 0.
REQ-022 ACTIVE -> DONE when the counter reaches MOSI_LEN.
  - rx_data <= assembled word on that same cycle.
  - rx_valid pulses for exactly 1 cycle.
REQ-023 DONE: further sck edges are ignored; DONE -> IDLE on synchronized ss high; busy = 0 on entry to IDLE.
REQ-024 ACTIVE with synchronized ss high before MOSI_LEN bits:
  - frame_err pulses for 1 cycle.
  - rx_data unchanged; no rx_valid.
  - Return to IDLE.
REQ-025 ss falling while in DONE (ss not yet seen high) shall be ignored until ss is seen high.
REQ-026 In IDLE, miso = 0 and sck edges are ignored.
REQ-027 Latency from the sck rising edge of the last bit to rx_valid = SYNC_STAGES + 1 clk cycles.
REQ-028 rx_data holds its value until the next completed frame.
REQ-029 A tx_data change during a frame has no effect on the frame in progress.

Reset
REQ-030 rst_n low shall asynchronously force:
  - FSM = IDLE.
  - miso = 0, busy = 0, rx_valid = 0, frame_err = 0.
  - rx_data = 0, counter = 0.
  - Synchronizer flops: sck = 1, ss = 1, mosi = 0.
REQ-031 Reset asserted mid-frame aborts the frame with no rx_valid or frame_err pulse; after release the slave waits for a new ss falling edge.

Structure
REQ-032 Package spi_pkg shall hold the FSM state type (IDLE/ACTIVE/DONE) and the default MOSI_LEN/MISO_LEN/SYNC_STAGES constants.
REQ-033 A sub-module sync_edge_det shall provide a resettable SYNC_STAGES-deep synchronizer with rise/fall pulse outputs; it is instantiated for sck and ss.

Verification
REQ-034 Frame: tx_data=8'hA5, master sends 12'hC3F at sck half-period 2 clk -> master receives 8'hA5; rx_data=12'hC3F; a single rx_valid pulse.
REQ-035 Abort: ss rises after 5 sck cycles -> frame_err pulse; rx_data keeps its previous value; busy=0; the next full frame 12'h001 is received correctly.
REQ-036 miso tail: tx_data=8'hFF, full 12-bit frame -> miso=1 for bits 0-7 and 0 for bits 8-11.
REQ-037 Back-to-back: frames 12'h123 then 12'hABC with ss high for 3 clk between them -> two rx_valid pulses with the correct data.
REQ-038 Reset: rst_n low after bit 6 -> all outputs at reset values immediately; no rx_valid; the following frame 12'h5A5 is correct.
REQ-039 tx_data changes mid-frame from 8'h0F to 8'hF0 -> master receives 8'h0F.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared types and default parameters for the SPI slave block.
//   - spi_state_t : frame FSM states (IDLE / ACTIVE / DONE)
//   - DEF_*       : default frame lengths and synchronizer depth
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int DEF_MOSI_LEN    = 12;
    localparam int DEF_MISO_LEN    = 8;
    localparam int DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } spi_state_t;

endpackage : spi_pkg

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
//   STAGES-deep synchronizer for an asynchronous input, with single-cycle
//   rise/fall pulses derived from the synchronized level.
//   Ports:
//     clk, rst_n : system clock, asynchronous active-low reset
//     din        : asynchronous input
//     level      : synchronized input (last synchronizer stage)
//     rise, fall : one-cycle pulses on a synchronized 0->1 / 1->0 transition
//   RESET_VAL sets the idle level the chain holds in reset, so that leaving
//   reset with the input at its idle level produces no spurious edge.
// -----------------------------------------------------------------------------
module sync_edge_det
    import spi_pkg::*;
#(
    parameter int   STAGES    = DEF_SYNC_STAGES,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop in the chain samples the value its neighbour held before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  =  level & ~prev_q;
    assign fall  = ~level &  prev_q;

endmodule : sync_edge_det

// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//   CPOL=1, MSB-first SPI slave running entirely in the clk domain.
//   sck/ss/mosi are oversampled through SYNC_STAGES flops; mosi is taken from
//   the same stage as sck so data and clock stay aligned.
//   Ports:
//     clk, rst_n : system clock, asynchronous active-low reset
//     sck        : SPI clock from the master (idles high)
//     ss         : slave select, active low
//     mosi       : serial data in
//     miso       : serial data out (0 when idle or once MISO_LEN bits sent)
//     tx_data    : word to send, captured when the frame starts
//     rx_data    : last complete received word
//     rx_valid   : one-cycle pulse when rx_data updates
//     busy       : high from frame start until the FSM returns to IDLE
//     frame_err  : one-cycle pulse when ss deasserts before MOSI_LEN bits
//   Assumes MOSI_LEN >= 2, 2 <= MISO_LEN <= MOSI_LEN, and sck phases of at
//   least 2 clk cycles each.
// -----------------------------------------------------------------------------
module spi_slave
    import spi_pkg::*;
#(
    parameter int MOSI_LEN    = DEF_MOSI_LEN,
    parameter int MISO_LEN    = DEF_MISO_LEN,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sck,
    input  logic                ss,
    input  logic                mosi,
    output logic                miso,
    input  logic [MISO_LEN-1:0] tx_data,
    output logic [MOSI_LEN-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy,
    output logic                frame_err
);

    localparam int CNT_W = $clog2(MOSI_LEN + 1);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic sck_level, sck_rise, sck_fall;
    logic ss_level, ss_rise, ss_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ss),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // Only the sck rising edge and the ss level/falling edge are needed.
    logic unused_sync;
    assign unused_sync = &{1'b0, sck_level, sck_fall, ss_rise};

    // mosi needs no edge detection, only the same depth as sck.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q[0] <= mosi;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                mosi_sync_q[i] <= mosi_sync_q[i-1];
            end
        end
    end

    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    spi_state_t state_q, state_d;

    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_inc;
    logic                last_bit;
    logic                more_tx;
    logic [MOSI_LEN-2:0] rx_shift_q;
    logic [MOSI_LEN-1:0] rx_next;
    // Holds the tx bits still to be sent after the one currently on miso.
    logic [MISO_LEN-2:0] tx_shift_q;

    assign count_inc = count_q + CNT_W'(1);
    assign last_bit  = (count_q == CNT_W'(MOSI_LEN - 1));
    assign more_tx   = (count_inc < CNT_W'(MISO_LEN));
    assign rx_next   = {rx_shift_q, mosi_s};

    // NOTE: all control and data flops are reset; a frame aborted by reset
    // must leave nothing behind that could later look like valid data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the default assignment first keeps this block free of latches
    // on every path through the case statement.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (ss_fall) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (ss_level)                  state_d = IDLE;
                else if (sck_rise && last_bit) state_d = DONE;
            end
            DONE: begin
                // A new ss falling edge here is intentionally lost: the
                // master must deassert ss before another frame can start.
                if (ss_level) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    // ------------------------------------------------------------------
    // Datapath: shift registers, counter, registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            miso       <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    miso <= 1'b0;
                    if (ss_fall) begin
                        miso       <= tx_data[MISO_LEN-1];
                        tx_shift_q <= tx_data[MISO_LEN-2:0];
                        count_q    <= '0;
                    end
                end
                ACTIVE: begin
                    if (ss_level) begin
                        frame_err <= 1'b1;
                        miso      <= 1'b0;
                        count_q   <= '0;
                    end else if (sck_rise) begin
                        count_q    <= count_inc;
                        rx_shift_q <= rx_next[MOSI_LEN-2:0];
                        tx_shift_q <= tx_shift_q << 1;
                        miso       <= more_tx ? tx_shift_q[MISO_LEN-2] : 1'b0;
                        if (last_bit) begin
                            rx_data  <= rx_next;
                            rx_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    miso <= 1'b0;
                end
                default: begin
                    miso <= 1'b0;
                end
            endcase
        end
    end

endmodule : spi_slave

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//   Directed bench for spi_slave. A master task bit-bangs CPOL=1 frames
//   (mosi changes on sck low, miso sampled on sck rise). Expected rx words
//   are queued before each frame; a monitor pops and compares on every
//   rx_valid pulse and counts frame_err pulses.
// -----------------------------------------------------------------------------
module tb_spi_slave;

    localparam int MOSI_LEN    = 12;
    localparam int MISO_LEN    = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 2;   // sck half-period in clk cycles

    logic                clk;
    logic                rst_n;
    logic                sck;
    logic                ss;
    logic                mosi;
    logic                miso;
    logic [MISO_LEN-1:0] tx_data;
    logic [MOSI_LEN-1:0] rx_data;
    logic                rx_valid;
    logic                busy;
    logic                frame_err;

    int total;
    int bad;
    int n_valid;
    int n_err;
    logic [MOSI_LEN-1:0] exp_rx[$];
    logic [MOSI_LEN-1:0] got_miso;

    spi_slave #(
        .MOSI_LEN    (MOSI_LEN),
        .MISO_LEN    (MISO_LEN),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck       (sck),
        .ss        (ss),
        .mosi      (mosi),
        .miso      (miso),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .busy      (busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: samples on the falling clk edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                n_valid++;
                if (exp_rx.size() == 0) check("spurious_rx_valid", 32'(rx_valid), 32'd0);
                else                    check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
            end
            if (frame_err) n_err++;
        end
    end

    // Master: optionally deasserts ss at the end and idles for gap clks.
    task automatic spi_frame(input logic [MOSI_LEN-1:0] word, input logic [MISO_LEN-1:0] tx,
                             input int nbits, input bit end_ss, input int gap,
                             input bit change_tx, input logic [MISO_LEN-1:0] tx_mid,
                             output logic [MOSI_LEN-1:0] miso_word);
        miso_word = '0;
        @(negedge clk);
        tx_data = tx;
        ss      = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_in_frame", 32'(busy), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            sck  = 1'b0;
            mosi = word[MOSI_LEN-1-i];
            repeat (HALF) @(negedge clk);
            sck       = 1'b1;
            miso_word = {miso_word[MOSI_LEN-2:0], miso};
            if (change_tx && i == 0) tx_data = tx_mid;
            repeat (HALF) @(negedge clk);
        end
        if (end_ss) begin
            repeat (2) @(negedge clk);
            ss = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic full_frame(input logic [MOSI_LEN-1:0] word, input logic [MISO_LEN-1:0] tx,
                              input int gap, input bit change_tx, input logic [MISO_LEN-1:0] tx_mid,
                              input logic [MOSI_LEN-1:0] exp_miso, input string name);
        exp_rx.push_back(word);
        spi_frame(word, tx, MOSI_LEN, 1'b1, gap, change_tx, tx_mid, got_miso);
        check(name, 32'(got_miso), 32'(exp_miso));
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        n_valid = 0;
        n_err   = 0;
        rst_n   = 1'b0;
        sck     = 1'b1;
        ss      = 1'b1;
        mosi    = 1'b0;
        tx_data = '0;
        repeat (3) @(negedge clk);
        check("reset_miso",      32'(miso),      32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_rx_valid",  32'(rx_valid),  32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_rx_data",   32'(rx_data),   32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame: master receives A5 then four zero tail bits.
        full_frame(12'hC3F, 8'hA5, 10, 1'b0, 8'h00, 12'hA50, "miso_a5");
        check("busy_after_frame", 32'(busy), 32'd0);
        check("rx_hold_c3f", 32'(rx_data), 32'hC3F);

        // Abort after 5 bits.
        spi_frame(12'hFFF, 8'h3C, 5, 1'b1, 10, 1'b0, 8'h00, got_miso);
        check("abort_frame_err_count", 32'(n_err), 32'd1);
        check("abort_rx_data_kept", 32'(rx_data), 32'hC3F);
        check("abort_busy", 32'(busy), 32'd0);
        full_frame(12'h001, 8'h81, 10, 1'b0, 8'h00, 12'h810, "miso_81");

        // miso tail with all-ones tx word.
        full_frame(12'h800, 8'hFF, 10, 1'b0, 8'h00, 12'hFF0, "miso_tail_ff");

        // Back-to-back, ss high for 3 clk between frames.
        full_frame(12'h123, 8'h12, 2, 1'b0, 8'h00, 12'h120, "miso_b2b_1");
        full_frame(12'hABC, 8'h34, 10, 1'b0, 8'h00, 12'h340, "miso_b2b_2");
        check("rx_hold_abc", 32'(rx_data), 32'hABC);

        // Reset after bit 6: outputs at reset values immediately.
        spi_frame(12'hFFF, 8'hFF, 6, 1'b0, 0, 1'b0, 8'h00, got_miso);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_miso",      32'(miso),      32'd0);
        check("midreset_busy",      32'(busy),      32'd0);
        check("midreset_rx_valid",  32'(rx_valid),  32'd0);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        check("midreset_rx_data",   32'(rx_data),   32'd0);
        ss = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("after_reset_busy", 32'(busy), 32'd0);
        full_frame(12'h5A5, 8'h96, 10, 1'b0, 8'h00, 12'h960, "miso_96");

        // tx_data change mid-frame must not affect the frame in progress.
        full_frame(12'h0F0, 8'h0F, 10, 1'b1, 8'hF0, 12'h0F0, "miso_tx_change");

        for (int i = 0; i < 100 && exp_rx.size() != 0; i++) @(negedge clk);
        check("scoreboard_empty", 32'(exp_rx.size()), 32'd0);
        check("rx_valid_count", 32'(n_valid), 32'd7);
        check("frame_err_count", 32'(n_err), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_slave
